// File: rtl/wpa_pkg.sv
// Shared types and helpers for the two-channel write port arbiter.
package wpa_pkg;

  localparam int unsigned ENTRY_ADDR_WIDTH = 3;
  localparam int unsigned ENTRY_DATA_WIDTH = 8;

  localparam int unsigned CH1 = 0;
  localparam int unsigned CH2 = 1;

  typedef struct packed {
    logic [ENTRY_ADDR_WIDTH-1:0] addr;
    logic [ENTRY_DATA_WIDTH-1:0] data;
  } wpa_entry_t;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wpa_fifo.sv
// Per-channel synchronous FIFO with occupancy count and combinational head.
module wpa_fifo
  import wpa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic                              push,
  input  logic                              pop,
  input  wpa_entry_t                        wr_entry,
  output wpa_entry_t                        head,
  output logic                              full,
  output logic                              empty,
  output logic [level_width(DEPTH)-1:0]     level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  wpa_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/write_port_arbiter.sv
// Buffers two write channels and issues them to the RAM's two write ports,
// serialising same-address pairs with round-robin priority.
module write_port_arbiter
  import wpa_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ENTRY_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ENTRY_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                 aclk,
  input  logic                                 srst,
  input  logic                                 hold,
  input  logic                                 s1_valid,
  output logic                                 s1_ready,
  input  logic [ADDR_WIDTH-1:0]                s1_addr,
  input  logic [DATA_WIDTH-1:0]                s1_data,
  input  logic                                 s2_valid,
  output logic                                 s2_ready,
  input  logic [ADDR_WIDTH-1:0]                s2_addr,
  input  logic [DATA_WIDTH-1:0]                s2_data,
  output logic                                 wren1,
  output logic [ADDR_WIDTH-1:0]                wraddr1,
  output logic [DATA_WIDTH-1:0]                wrdata1,
  output logic                                 wren2,
  output logic [ADDR_WIDTH-1:0]                wraddr2,
  output logic [DATA_WIDTH-1:0]                wrdata2,
  output logic                                 collision,
  output logic [CNT_WIDTH-1:0]                 collision_cnt,
  output logic [level_width(FIFO_DEPTH)-1:0]   level1,
  output logic [level_width(FIFO_DEPTH)-1:0]   level2
);

  // The shared entry struct is sized by the package; reject mismatched builds.
  if (ADDR_WIDTH != ENTRY_ADDR_WIDTH || DATA_WIDTH != ENTRY_DATA_WIDTH) begin : g_width_check
    $error("write_port_arbiter: ADDR_WIDTH/DATA_WIDTH must match wpa_pkg entry widths");
  end

  wpa_entry_t head1, head2;
  logic       full1, full2, empty1, empty2;
  logic       push1, push2, pop1, pop2, coll;
  logic       prio_q;

  assign s1_ready = !full1 && !srst;
  assign s2_ready = !full2 && !srst;
  assign push1    = s1_valid && s1_ready;
  assign push2    = s2_valid && s2_ready;

  wpa_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk      (aclk),
    .srst     (srst),
    .push     (push1),
    .pop      (pop1),
    .wr_entry ('{addr: s1_addr, data: s1_data}),
    .head     (head1),
    .full     (full1),
    .empty    (empty1),
    .level    (level1)
  );

  wpa_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk      (aclk),
    .srst     (srst),
    .push     (push2),
    .pop      (pop2),
    .wr_entry ('{addr: s2_addr, data: s2_data}),
    .head     (head2),
    .full     (full2),
    .empty    (empty2),
    .level    (level2)
  );

  // Issue decision on the FIFO heads; only the priority holder pops on an address clash.
  always_comb begin
    pop1 = 1'b0;
    pop2 = 1'b0;
    coll = 1'b0;
    if (!hold) begin
      if (!empty1 && !empty2 && (head1.addr == head2.addr)) begin
        coll = 1'b1;
        pop1 = (prio_q == 1'(CH1));
        pop2 = (prio_q == 1'(CH2));
      end else begin
        pop1 = !empty1;
        pop2 = !empty2;
      end
    end
  end

  // Registered write ports; address/data hold their last issued value when idle.
  always_ff @(posedge aclk) begin
    if (srst) begin
      wren1         <= 1'b0;
      wraddr1       <= '0;
      wrdata1       <= '0;
      wren2         <= 1'b0;
      wraddr2       <= '0;
      wrdata2       <= '0;
      collision     <= 1'b0;
      collision_cnt <= '0;
      prio_q        <= 1'(CH1);
    end else begin
      wren1     <= pop1;
      wren2     <= pop2;
      collision <= coll;
      if (pop1) begin
        wraddr1 <= head1.addr;
        wrdata1 <= head1.data;
      end
      if (pop2) begin
        wraddr2 <= head2.addr;
        wrdata2 <= head2.data;
      end
      if (coll) begin
        prio_q <= ~prio_q;
        if (collision_cnt != '1) collision_cnt <= collision_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed bench for write_port_arbiter with per-port expected-write queues.
module tb_write_port_arbiter;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned LW    = 3;

  logic          aclk = 1'b0;
  logic          srst, hold;
  logic          s1_valid, s1_ready, s2_valid, s2_ready;
  logic [AW-1:0] s1_addr, s2_addr, wraddr1, wraddr2;
  logic [DW-1:0] s1_data, s2_data, wrdata1, wrdata2;
  logic          wren1, wren2, collision;
  logic [CW-1:0] collision_cnt;
  logic [LW-1:0] level1, level2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;

  write_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk          (aclk),
    .srst          (srst),
    .hold          (hold),
    .s1_valid      (s1_valid),
    .s1_ready      (s1_ready),
    .s1_addr       (s1_addr),
    .s1_data       (s1_data),
    .s2_valid      (s2_valid),
    .s2_ready      (s2_ready),
    .s2_addr       (s2_addr),
    .s2_data       (s2_data),
    .wren1         (wren1),
    .wraddr1       (wraddr1),
    .wrdata1       (wrdata1),
    .wren2         (wren2),
    .wraddr2       (wraddr2),
    .wrdata2       (wrdata2),
    .collision     (collision),
    .collision_cnt (collision_cnt),
    .level1        (level1),
    .level2        (level2)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  // Every issued write must match the oldest outstanding expectation for its port.
  task automatic sb_check();
    exp_t e;
    if (wren1 === 1'b1) begin
      if (q1.size() == 0) chk("p1_unexpected_wren", 32'(wren1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("p1_addr", 32'(wraddr1), 32'(e.addr));
        chk("p1_data", 32'(wrdata1), 32'(e.data));
      end
    end
    if (wren2 === 1'b1) begin
      if (q2.size() == 0) chk("p2_unexpected_wren", 32'(wren2), 32'd0);
      else begin
        e = q2.pop_front();
        chk("p2_addr", 32'(wraddr2), 32'(e.addr));
        chk("p2_data", 32'(wrdata2), 32'(e.data));
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    sb_check();
  endtask

  task automatic drive(input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic v2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    s2_valid = v2; s2_addr = a2; s2_data = d2;
  endtask

  // Same-address pair: winner issues first with a collision pulse, loser one cycle later.
  task automatic collide(input logic [AW-1:0] a, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input int win, input int cnt_exp);
    drive(1'b1, a, d1, 1'b1, a, d2);
    q1.push_back(exp_t'{addr: a, data: d1});
    q2.push_back(exp_t'{addr: a, data: d2});
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    chk("coll_pulse",     32'(collision),     32'd1);
    chk("coll_win_p1",    32'(wren1),         32'(win == 1));
    chk("coll_win_p2",    32'(wren2),         32'(win == 2));
    chk("coll_cnt",       32'(collision_cnt), 32'(cnt_exp));
    step();
    chk("coll_pulse_end", 32'(collision),     32'd0);
    chk("coll_lose_p1",   32'(wren1),         32'(win == 2));
    chk("coll_lose_p2",   32'(wren2),         32'(win == 1));
    chk("coll_cnt_hold",  32'(collision_cnt), 32'(cnt_exp));
  endtask

  initial begin
    srst = 1'b1;
    hold = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    step();
    chk("rst_ready1",  32'(s1_ready),      32'd0);
    chk("rst_ready2",  32'(s2_ready),      32'd0);
    chk("rst_wren1",   32'(wren1),         32'd0);
    chk("rst_wren2",   32'(wren2),         32'd0);
    chk("rst_wraddr1", 32'(wraddr1),       32'd0);
    chk("rst_wrdata1", 32'(wrdata1),       32'd0);
    chk("rst_wraddr2", 32'(wraddr2),       32'd0);
    chk("rst_wrdata2", 32'(wrdata2),       32'd0);
    chk("rst_coll",    32'(collision),     32'd0);
    chk("rst_cnt",     32'(collision_cnt), 32'd0);
    chk("rst_level1",  32'(level1),        32'd0);
    chk("rst_level2",  32'(level2),        32'd0);
    srst = 1'b0;
    step();
    chk("ready1_after_rst", 32'(s1_ready), 32'd1);
    chk("ready2_after_rst", 32'(s2_ready), 32'd1);

    // Single write, two-edge latency
    drive(1'b1, 3'd3, 8'hA5, 1'b0, '0, '0);
    q1.push_back(exp_t'{addr: 3'd3, data: 8'hA5});
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("single_not_yet", 32'(wren1), 32'd0);
    step();
    chk("single_wren1",   32'(wren1),         32'd1);
    chk("single_wraddr1", 32'(wraddr1),       32'd3);
    chk("single_wrdata1", 32'(wrdata1),       32'hA5);
    chk("single_wren2",   32'(wren2),         32'd0);
    chk("single_cnt",     32'(collision_cnt), 32'd0);
    step();
    chk("single_idle",    32'(wren1),   32'd0);
    chk("single_hold_a",  32'(wraddr1), 32'd3);

    // Parallel writes to different addresses
    drive(1'b1, 3'd2, 8'h11, 1'b1, 3'd6, 8'h22);
    q1.push_back(exp_t'{addr: 3'd2, data: 8'h11});
    q2.push_back(exp_t'{addr: 3'd6, data: 8'h22});
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    chk("par_wren1", 32'(wren1),     32'd1);
    chk("par_wren2", 32'(wren2),     32'd1);
    chk("par_coll",  32'(collision), 32'd0);
    step();

    // Collisions alternate priority
    collide(3'd5, 8'h11, 8'h22, 1, 1);
    collide(3'd5, 8'h33, 8'h44, 2, 2);
    step();
    chk("idle_wrdata2_held", 32'(wrdata2), 32'h44);

    // Backpressure under hold
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), DW'(i), 1'b0, '0, '0);
      chk("bp_ready_pre", 32'(s1_ready), 32'd1);
      q1.push_back(exp_t'{addr: AW'(i), data: DW'(i)});
      step();
      chk("bp_no_issue", 32'(wren1), 32'd0);
    end
    drive(1'b1, 3'd4, 8'd4, 1'b0, '0, '0);
    chk("bp_full_ready", 32'(s1_ready), 32'd0);
    chk("bp_full_level", 32'(level1),   32'd4);
    step();
    chk("bp_stay_ready", 32'(s1_ready), 32'd0);
    chk("bp_stay_level", 32'(level1),   32'd4);
    chk("bp_stay_wren",  32'(wren1),    32'd0);
    hold = 1'b0;
    step();
    chk("bp_rel_wren",   32'(wren1),    32'd1);
    chk("bp_rel_level",  32'(level1),   32'd3);
    chk("bp_rel_ready",  32'(s1_ready), 32'd1);
    q1.push_back(exp_t'{addr: 3'd4, data: 8'd4});
    step();
    chk("bp_flow_wren",  32'(wren1),  32'd1);
    chk("bp_flow_level", 32'(level1), 32'd3);
    drive(1'b1, 3'd5, 8'd5, 1'b0, '0, '0);
    q1.push_back(exp_t'{addr: 3'd5, data: 8'd5});
    step();
    chk("bp_flow_wren",  32'(wren1),  32'd1);
    chk("bp_flow_level", 32'(level1), 32'd3);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 2; i >= 0; i--) begin
      step();
      chk("bp_drain_wren",  32'(wren1),  32'd1);
      chk("bp_drain_level", 32'(level1), 32'(i));
    end
    step();
    chk("bp_done_wren", 32'(wren1), 32'd0);

    // Leave priority at channel 2, then reset with both FIFOs loaded
    collide(3'd7, 8'hAA, 8'hBB, 1, 3);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(i + 1), DW'(8'h60 + i), 1'b1, AW'(i + 1), DW'(8'h70 + i));
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("mid_level1", 32'(level1), 32'd3);
    chk("mid_level2", 32'(level2), 32'd3);
    srst = 1'b1;
    step();
    chk("mid_rst_level1", 32'(level1),        32'd0);
    chk("mid_rst_level2", 32'(level2),        32'd0);
    chk("mid_rst_ready1", 32'(s1_ready),      32'd0);
    chk("mid_rst_cnt",    32'(collision_cnt), 32'd0);
    srst = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_no_wren1", 32'(wren1), 32'd0);
      chk("mid_rst_no_wren2", 32'(wren2), 32'd0);
    end

    // Priority back at channel 1, then drive the counter into saturation
    collide(3'd2, 8'hCC, 8'hDD, 1, 1);
    collide(3'd0, 8'h81, 8'h91, 2, 2);
    collide(3'd0, 8'h82, 8'h92, 1, 3);
    collide(3'd0, 8'h83, 8'h93, 2, 3);
    collide(3'd0, 8'h84, 8'h94, 1, 3);

    step();
    chk("sb_q1_drained", 32'(q1.size()), 32'd0);
    chk("sb_q2_drained", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
